// File: rtl/dot8_acc.sv
// dot8_acc: one processing row of the matrix-vector datapath.
// It reads 64-bit FIFO words as LANES signed lanes and multiplies each lane
// by the matching lane of a weight word captured at job start. The products
// are accumulated over len words, and the final sum is returned through a
// valid/ready handshake.
//
// Ports:
//   clk, rst           single clock; synchronous active-high reset
//   start, len, w_data job request (sampled only in IDLE), word count, weights
//   in_vld, in_data    upstream word stream (FIFO q)
//   in_rdy             word accepted when in_vld & in_rdy (drives FIFO en)
//   res_vld, res       accumulated dot product, held until res_rdy
//   res_rdy            downstream accepts the result
//   busy               high whenever the row is not IDLE
//
// Build option: define DOT8_SAT_EN to make the accumulate saturate at the
// signed ACC_BITS bounds instead of wrapping. Timing is identical either way.
module dot8_acc #(
  parameter int LANES     = 8,
  parameter int LANE_BITS = 8,
  parameter int ACC_BITS  = 32,
  parameter int LEN_BITS  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [LEN_BITS-1:0]               len,
  input  logic [LANES*LANE_BITS-1:0]        w_data,
  input  logic                              in_vld,
  input  logic [LANES*LANE_BITS-1:0]        in_data,
  output logic                              in_rdy,
  output logic                              res_vld,
  output logic signed [ACC_BITS-1:0]        res,
  input  logic                              res_rdy,
  output logic                              busy
);

  localparam int PROD_W = 2 * LANE_BITS;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam int EXT_W  = ((ACC_BITS > SUM_W) ? ACC_BITS : SUM_W) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                          state, state_nxt;
  logic [LEN_BITS-1:0]             remaining;
  logic [LANES*LANE_BITS-1:0]      w_reg;
  logic                            accept;
  logic                            start_job;
  logic                            last_word;
  logic signed [PROD_W-1:0]        prod_c  [LANES];
  logic signed [PROD_W-1:0]        prod_p1 [LANES];
  logic                            vld_p1;
  logic signed [SUM_W-1:0]         sum_p1;

  // Signed lane multiply; both operands are widened first so the product
  // is formed at full precision.
  function automatic logic signed [PROD_W-1:0] lane_mul(
    input logic signed [LANE_BITS-1:0] a,
    input logic signed [LANE_BITS-1:0] b
  );
    logic signed [PROD_W-1:0] ae;
    logic signed [PROD_W-1:0] be;
    ae = {{LANE_BITS{a[LANE_BITS-1]}}, a};
    be = {{LANE_BITS{b[LANE_BITS-1]}}, b};
    return ae * be;
  endfunction

  // Accumulate step. The add is done one bit wider than either operand, so
  // the saturating build can see the true sum before it clamps.
  function automatic logic signed [ACC_BITS-1:0] acc_add(
    input logic signed [ACC_BITS-1:0] acc,
    input logic signed [SUM_W-1:0]    term
  );
    logic signed [EXT_W-1:0] ae;
    logic signed [EXT_W-1:0] te;
    logic signed [EXT_W-1:0] s;
`ifdef DOT8_SAT_EN
    logic signed [EXT_W-1:0] sat_max;
    logic signed [EXT_W-1:0] sat_min;
`else
    logic                    unused_hi;
`endif
    ae = {{(EXT_W-ACC_BITS){acc[ACC_BITS-1]}}, acc};
    te = {{(EXT_W-SUM_W){term[SUM_W-1]}}, term};
    s  = ae + te;
`ifdef DOT8_SAT_EN
    sat_max = {{(EXT_W-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
    sat_min = {{(EXT_W-ACC_BITS+1){1'b1}}, {(ACC_BITS-1){1'b0}}};
    if (s > sat_max) begin
      return sat_max[ACC_BITS-1:0];
    end else if (s < sat_min) begin
      return sat_min[ACC_BITS-1:0];
    end
    return s[ACC_BITS-1:0];
`else
    unused_hi = ^s[EXT_W-1:ACC_BITS];
    return s[ACC_BITS-1:0];
`endif
  endfunction

  // Control FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control FSM: next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    res_vld   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_rdy = 1'b1;
        if (in_vld && (remaining == LEN_BITS'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        res_vld = 1'b1;
        if (res_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept    = in_vld & in_rdy;
  assign start_job = (state == IDLE) & start;
  assign last_word = accept & (remaining == LEN_BITS'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
    end else if (start_job) begin
      remaining <= len;
    end else if (accept) begin
      remaining <= remaining - LEN_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start_job) begin
      w_reg <= w_data;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = lane_mul(w_reg[i*LANE_BITS +: LANE_BITS],
                           in_data[i*LANE_BITS +: LANE_BITS]);
    end
  end

  // Stage 1: lane products of the accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod_p1[i] <= '0;
      end
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          prod_p1[i] <= prod_c[i];
        end
      end
    end
  end

  always_comb begin
    sum_p1 = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_p1 = sum_p1 + {{(SUM_W-PROD_W){prod_p1[i][PROD_W-1]}}, prod_p1[i]};
    end
  end

  // Stage 2: lane sum folded into the accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
    end else if (start_job) begin
      res <= '0;
    end else if (vld_p1) begin
      res <= acc_add(res, sum_p1);
    end
  end

  // The final word has been counted in the FSM compare; keep last_word for
  // readability of the accept path.
  logic unused_last;
  assign unused_last = last_word;

endmodule

// File: doc/dot8_acc.md
Name: dot8_acc

Overview:
- Downstream consumer of the delay-buffer FIFO. Takes its 64-bit output words as 8 signed 8-bit lanes and forms the dot product with a weight word captured at job start.
- Accumulates over a programmed number of words, then presents a single result through a valid/ready handshake.
- Forms one processing row of the matrix-vector datapath behind the CCI-P MMIO front end.

Parameters:
- LANES, 8, number of lanes per input word.
- LANE_BITS, 8, signed width of each lane (data and weight).
- ACC_BITS, 32, accumulator and result width.
- LEN_BITS, 8, width of the job length field.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- len  input  LEN_BITS  number of data words in the job; sampled with start.
- w_data  input  LANES*LANE_BITS  packed signed weights (lane i = bits [8i+7:8i]); sampled with start.
- in_vld  input  1  upstream word valid.
- in_data  input  LANES*LANE_BITS  packed signed data word (FIFO q).
- in_rdy  output  1  word accepted when in_vld & in_rdy; upstream FIFO en is driven from this product.
- res_vld  output  1  result valid.
- res  output  ACC_BITS  signed accumulated dot product.
- res_rdy  input  1  downstream accepts result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - res=0, res_vld=0, in_rdy=0, busy=0.
  - Remaining-word counter, product pipeline registers and pipeline valid are all cleared.
  - Reset mid-job abandons the job: no result is produced, and any partially consumed words are lost.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE, on start=1:
  - Capture w_data and len; clear accumulator (res=0).
  - If len=0, go to DONE; otherwise load remaining=len and go to ACCUM.
- ACCUM:
  - in_rdy=1 combinationally in this state only.
  - Each accepted word decrements remaining.
  - On the acceptance of the word that brings remaining to 0, go to DRAIN.
  - in_vld=0 cycles stall indefinitely with no effect.
- Pipeline:
  - Stage 1: register the 8 signed products w[i]*d[i] (16 bits each) plus a valid bit, at the edge ending the accept cycle.
  - Stage 2: sum the 8 products to 19 bits signed, sign-extend to ACC_BITS, and add into res at the next edge.
  - Accumulation wraps modulo 2^ACC_BITS.
- DRAIN: lasts exactly one cycle, during which stage 2 absorbs the final product. Then go to DONE.
- Latency: final word accepted in cycle t → res_vld=1 and res final in cycle t+2.
- DONE:
  - res_vld=1; res is held stable while res_rdy=0.
  - On res_vld & res_rdy, go to IDLE, with res_vld=0 next cycle.
  - res keeps its value until the next start.
- Start handling: start outside IDLE is ignored, including in the DONE handoff cycle. A new job needs start in a later IDLE cycle.
- in_vld while not in ACCUM: not consumed (in_rdy=0), so the FIFO does not shift.
- len wrap: len = 2^LEN_BITS-1 is the maximum; the counter never wraps.

Optional Feature:
- Macro DOT8_SAT_EN.
- Defined: the stage-2 add saturates to signed ACC_BITS bounds, +2^(ACC_BITS-1)-1 and -2^(ACC_BITS-1). Once saturated, later terms of the opposite sign move the value back off the bound normally.
- Undefined: plain two's-complement wrap.
- Timing and handshake are identical in both builds.

Test Plan:
- Single word: w_data=0x0101010101010101, len=1, in_data=0x0102030405060708 → res_vld two cycles after accept, res=36.
- Negative accumulate: w_data=0xFFFFFFFFFFFFFFFF, len=4, four words of 0x7F7F7F7F7F7F7F7F with in_vld gaps → exactly 4 accepts, res=0xFFFFF020 (-4064), in_rdy=0 after the 4th accept.
- len=0: start with len=0 → DONE next cycle, res_vld=1, res=0, no words consumed while in_vld=1.
- Backpressure: hold res_rdy=0 for 5 cycles in DONE and pulse start → res_vld and res stable, start ignored; res_rdy=1 → IDLE, busy=0 next cycle.
- Reset mid-ACCUM: rst=1 after 2 of len=5 words → next cycle state IDLE, res=0, res_vld=0, busy=0, in_rdy=0.
- Saturation: ACC_BITS=16, weights 0x7F, data 0x7F, len=3.
  - With DOT8_SAT_EN: res=0x7FFF.
  - Without DOT8_SAT_EN: res=(3*129032) mod 2^16 = 0xE818.
